// File: rtl/i2s_tx_sched.sv
// I2S transmit frame scheduler: bit/lrck framing, one-entry sample holding
// buffer with valid/ready intake, per-frame word load, mute and underrun tracking.
module i2s_tx_sched #(
  parameter int WORD_SIZE     = 32,
  parameter int SAMPLE_SIZE   = 24,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic                   i_bck,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_mute,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic [SAMPLE_SIZE-1:0] i_s_l_sample,
  input  logic [SAMPLE_SIZE-1:0] i_s_r_sample,
  output logic                   o_lrck,
  output logic [WORD_SIZE-1:0]   o_l_word,
  output logic [WORD_SIZE-1:0]   o_r_word,
  output logic                   o_frame_start,
  output logic                   o_underrun,
  input  logic                   i_underrun_clr,
  output logic [7:0]             o_underrun_cnt
);

  localparam int CNT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam int PAD   = WORD_SIZE - SAMPLE_SIZE;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;

  state_t                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_next;
  logic                   r_lrck, w_lrck_next;
  logic [WORD_SIZE-1:0]   r_l_word, w_l_word_next;
  logic [WORD_SIZE-1:0]   r_r_word, w_r_word_next;
  logic [SAMPLE_SIZE-1:0] r_pend_l, w_pend_l_next;
  logic [SAMPLE_SIZE-1:0] r_pend_r, w_pend_r_next;
  logic                   r_pend_full, w_pend_full_next;
  logic                   r_s_ready, w_s_ready_next;
  logic                   r_frame_start, w_frame_start_next;
  logic                   r_underrun, w_underrun_next;
  logic [7:0]             r_underrun_cnt, w_underrun_cnt_next;

  logic w_active, w_last_bit, w_load, w_hs;

  always_comb begin
    w_active   = (r_state != ST_IDLE);
    w_last_bit = (r_bit_cnt == CNT_W'(WORD_SIZE - 1));
    w_load     = w_active && r_lrck && w_last_bit;
    w_hs       = i_s_valid && r_s_ready;

    w_state_next        = r_state;
    w_bit_cnt_next      = r_bit_cnt;
    w_lrck_next         = r_lrck;
    w_l_word_next       = r_l_word;
    w_r_word_next       = r_r_word;
    w_pend_l_next       = r_pend_l;
    w_pend_r_next       = r_pend_r;
    w_pend_full_next    = r_pend_full;
    w_underrun_next     = r_underrun;
    w_underrun_cnt_next = r_underrun_cnt;

    case (r_state)
      ST_IDLE: if (i_en) w_state_next = ST_RUN;
      ST_RUN, ST_STOP: begin
        // en decides per edge, so a STOP that sees en again resumes seamlessly
        w_state_next = i_en ? ST_RUN : ST_STOP;
        if (w_load && !i_en) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_active) begin
      w_bit_cnt_next = w_last_bit ? '0 : r_bit_cnt + 1'b1;
      if (w_last_bit) w_lrck_next = ~r_lrck;
    end

    if (w_load) begin
      w_pend_full_next = 1'b0;
      if (!i_en) begin
        w_l_word_next = '0;
        w_r_word_next = '0;
      end else if (r_pend_full) begin
        w_l_word_next = i_mute ? '0 : (WORD_SIZE'(r_pend_l) << PAD);
        w_r_word_next = i_mute ? '0 : (WORD_SIZE'(r_pend_r) << PAD);
      end else begin
        if (i_mute || UNDERRUN_HOLD == 0) begin
          w_l_word_next = '0;
          w_r_word_next = '0;
        end
        w_underrun_next = 1'b1;
        if (r_underrun_cnt != 8'hFF) w_underrun_cnt_next = r_underrun_cnt + 8'd1;
      end
    end

    // A pair taken on the final STOP edge is dropped with the rest of the buffer
    if (w_hs && w_state_next != ST_IDLE) begin
      w_pend_l_next    = i_s_l_sample;
      w_pend_r_next    = i_s_r_sample;
      w_pend_full_next = 1'b1;
    end

    if (i_underrun_clr && !(w_load && i_en && !r_pend_full)) w_underrun_next = 1'b0;

    w_s_ready_next     = (w_state_next != ST_IDLE) && !w_pend_full_next;
    w_frame_start_next = (w_state_next != ST_IDLE) && (w_bit_cnt_next == '0) && !w_lrck_next;
  end

  always_ff @(negedge i_bck) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_bit_cnt      <= '0;
      r_lrck         <= 1'b0;
      r_l_word       <= '0;
      r_r_word       <= '0;
      r_pend_l       <= '0;
      r_pend_r       <= '0;
      r_pend_full    <= 1'b0;
      r_s_ready      <= 1'b0;
      r_frame_start  <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_state        <= w_state_next;
      r_bit_cnt      <= w_bit_cnt_next;
      r_lrck         <= w_lrck_next;
      r_l_word       <= w_l_word_next;
      r_r_word       <= w_r_word_next;
      r_pend_l       <= w_pend_l_next;
      r_pend_r       <= w_pend_r_next;
      r_pend_full    <= w_pend_full_next;
      r_s_ready      <= w_s_ready_next;
      r_frame_start  <= w_frame_start_next;
      r_underrun     <= w_underrun_next;
      r_underrun_cnt <= w_underrun_cnt_next;
    end
  end

  assign o_s_ready      = r_s_ready;
  assign o_lrck         = r_lrck;
  assign o_l_word       = r_l_word;
  assign o_r_word       = r_r_word;
  assign o_frame_start  = r_frame_start;
  assign o_underrun     = r_underrun;
  assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Directed bench for i2s_tx_sched: a checkpoint table for the main scenario
// plus hand sequences for saturation, mid-frame reset and backpressure ordering.
module tb_i2s_tx_sched;

  logic        bck = 1'b0;
  logic        rst, en, mute, s_valid, underrun_clr;
  logic [23:0] l_s, r_s;
  logic        rdy0, lrck0, fs0, ur0, rdy1, lrck1, fs1, ur1;
  logic [31:0] lw0, rw0, lw1, rw1;
  logic [7:0]  cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 bck = ~bck;

  i2s_tx_sched #(.WORD_SIZE(32), .SAMPLE_SIZE(24), .UNDERRUN_HOLD(0)) dut0 (
    .i_bck(bck), .i_rst(rst), .i_en(en), .i_mute(mute), .i_s_valid(s_valid),
    .o_s_ready(rdy0), .i_s_l_sample(l_s), .i_s_r_sample(r_s), .o_lrck(lrck0),
    .o_l_word(lw0), .o_r_word(rw0), .o_frame_start(fs0), .o_underrun(ur0),
    .i_underrun_clr(underrun_clr), .o_underrun_cnt(cnt0));

  i2s_tx_sched #(.WORD_SIZE(32), .SAMPLE_SIZE(24), .UNDERRUN_HOLD(1)) dut1 (
    .i_bck(bck), .i_rst(rst), .i_en(en), .i_mute(mute), .i_s_valid(s_valid),
    .o_s_ready(rdy1), .i_s_l_sample(l_s), .i_s_r_sample(r_s), .o_lrck(lrck1),
    .o_l_word(lw1), .o_r_word(rw1), .o_frame_start(fs1), .o_underrun(ur1),
    .i_underrun_clr(underrun_clr), .o_underrun_cnt(cnt1));

  typedef struct {
    int          steps;
    logic        en, valid, mute, clr;
    logic [23:0] l, r;
    logic        lrck, fs, rdy;
    logic [31:0] lw, rw, lw1, rw1;
    logic        ur;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(int steps, logic e, logic v, logic m, logic c,
                              logic [23:0] l, logic [23:0] r, logic lr, logic fs,
                              logic rd, logic [31:0] lw, logic [31:0] rw,
                              logic [31:0] lwh, logic [31:0] rwh, logic ur, logic [7:0] cnt);
    vec_t x;
    x.steps = steps; x.en = e; x.valid = v; x.mute = m; x.clr = c; x.l = l; x.r = r;
    x.lrck = lr; x.fs = fs; x.rdy = rd; x.lw = lw; x.rw = rw; x.lw1 = lwh; x.rw1 = rwh;
    x.ur = ur; x.cnt = cnt;
    return x;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge bck);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".lrck"}, 32'(lrck0), 0);
    chk({tag, ".fs"},   32'(fs0),   0);
    chk({tag, ".rdy"},  32'(rdy0),  0);
    chk({tag, ".lw"},   lw0,        0);
    chk({tag, ".rw"},   rw0,        0);
    chk({tag, ".ur"},   32'(ur0),   0);
    chk({tag, ".cnt"},  32'(cnt0),  0);
    chk({tag, ".lw1"},  lw1,        0);
    chk({tag, ".cnt1"}, 32'(cnt1),  0);
  endtask

  localparam logic [31:0] PA = 32'h7FFFFF00, PB = 32'h80000000;
  localparam logic [31:0] P3L = 32'h12345600, P3R = 32'hABCDEF00;

  initial begin
    int k, f, rdy_cnt;
    logic go;
    vecs[0]  = mk( 1,1,1,0,0,24'h7FFFFF,24'h800000, 0,1,1, 0,0,0,0, 0,0);
    vecs[1]  = mk( 1,1,1,0,0,24'h7FFFFF,24'h800000, 0,0,0, 0,0,0,0, 0,0);
    vecs[2]  = mk(31,1,1,0,0,24'h7FFFFF,24'h800000, 1,0,0, 0,0,0,0, 0,0);
    vecs[3]  = mk(31,1,1,0,0,24'h7FFFFF,24'h800000, 1,0,0, 0,0,0,0, 0,0);
    vecs[4]  = mk( 1,1,1,0,0,24'h7FFFFF,24'h800000, 0,1,1, PA,PB,PA,PB, 0,0);
    vecs[5]  = mk( 1,1,1,0,0,24'h7FFFFF,24'h800000, 0,0,0, PA,PB,PA,PB, 0,0);
    vecs[6]  = mk(63,1,1,0,0,24'h7FFFFF,24'h800000, 0,1,1, PA,PB,PA,PB, 0,0);
    vecs[7]  = mk( 1,1,1,0,0,24'h123456,24'hABCDEF, 0,0,0, PA,PB,PA,PB, 0,0);
    vecs[8]  = mk(63,1,0,0,0,24'h123456,24'hABCDEF, 0,1,1, P3L,P3R,P3L,P3R, 0,0);
    vecs[9]  = mk(64,1,0,0,0,24'h123456,24'hABCDEF, 0,1,1, 0,0,P3L,P3R, 1,1);
    vecs[10] = mk(64,1,0,0,0,24'h123456,24'hABCDEF, 0,1,1, 0,0,P3L,P3R, 1,2);
    vecs[11] = mk( 1,1,0,0,1,24'h123456,24'hABCDEF, 0,0,1, 0,0,P3L,P3R, 0,2);
    vecs[12] = mk(62,1,0,0,0,24'h123456,24'hABCDEF, 1,0,1, 0,0,P3L,P3R, 0,2);
    vecs[13] = mk( 1,1,0,0,1,24'h123456,24'hABCDEF, 0,1,1, 0,0,P3L,P3R, 1,3);
    vecs[14] = mk( 1,1,1,0,1,24'h000001,24'h000002, 0,0,0, 0,0,P3L,P3R, 0,3);
    vecs[15] = mk(63,1,1,1,0,24'h000003,24'h000004, 0,1,1, 0,0,0,0, 0,3);
    vecs[16] = mk( 1,1,1,0,0,24'h000003,24'h000004, 0,0,0, 0,0,0,0, 0,3);
    vecs[17] = mk(63,1,1,0,0,24'h000003,24'h000004, 0,1,1, 32'h300,32'h400,32'h300,32'h400, 0,3);
    vecs[18] = mk( 1,1,1,0,0,24'h000005,24'h000006, 0,0,0, 32'h300,32'h400,32'h300,32'h400, 0,3);
    vecs[19] = mk( 9,1,1,0,0,24'h000005,24'h000006, 0,0,0, 32'h300,32'h400,32'h300,32'h400, 0,3);
    vecs[20] = mk( 1,0,1,0,0,24'h000005,24'h000006, 0,0,0, 32'h300,32'h400,32'h300,32'h400, 0,3);
    vecs[21] = mk(30,0,1,0,0,24'h000005,24'h000006, 1,0,0, 32'h300,32'h400,32'h300,32'h400, 0,3);
    vecs[22] = mk(22,0,1,0,0,24'h000005,24'h000006, 1,0,0, 32'h300,32'h400,32'h300,32'h400, 0,3);
    vecs[23] = mk( 1,0,1,0,0,24'h000005,24'h000006, 0,0,0, 0,0,0,0, 0,3);
    vecs[24] = mk( 5,0,1,0,0,24'h000005,24'h000006, 0,0,0, 0,0,0,0, 0,3);
    vecs[25] = mk( 1,1,0,0,0,24'h000005,24'h000006, 0,1,1, 0,0,0,0, 0,3);
    vecs[26] = mk(64,1,0,0,0,24'h000005,24'h000006, 0,1,1, 0,0,0,0, 1,4);

    rst = 1'b1; en = 1'b0; mute = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
    l_s = '0; r_s = '0;
    step(3);
    rst = 1'b0;
    chk_reset("reset");

    for (int i = 0; i < 27; i++) begin
      en = vecs[i].en; s_valid = vecs[i].valid; mute = vecs[i].mute;
      underrun_clr = vecs[i].clr; l_s = vecs[i].l; r_s = vecs[i].r;
      step(vecs[i].steps);
      chk($sformatf("v%0d.lrck", i), 32'(lrck0), 32'(vecs[i].lrck));
      chk($sformatf("v%0d.fs", i),   32'(fs0),   32'(vecs[i].fs));
      chk($sformatf("v%0d.rdy", i),  32'(rdy0),  32'(vecs[i].rdy));
      chk($sformatf("v%0d.lw", i),   lw0,        vecs[i].lw);
      chk($sformatf("v%0d.rw", i),   rw0,        vecs[i].rw);
      chk($sformatf("v%0d.lw1", i),  lw1,        vecs[i].lw1);
      chk($sformatf("v%0d.rw1", i),  rw1,        vecs[i].rw1);
      chk($sformatf("v%0d.ur", i),   32'(ur0),   32'(vecs[i].ur));
      chk($sformatf("v%0d.cnt", i),  32'(cnt0),  32'(vecs[i].cnt));
    end

    // Starve until the counter saturates, then keep starving.
    step(64 * 251);
    chk("sat.cnt255", 32'(cnt0), 32'd255);
    chk("sat.ur",     32'(ur0),  32'd1);
    step(128);
    chk("sat.hold", 32'(cnt0), 32'd255);
    chk("sat.hold1", 32'(cnt1), 32'd255);

    // Reset in the middle of the right slot.
    step(40);
    chk("midr.lrck", 32'(lrck0), 32'd1);
    rst = 1'b1;
    step(1);
    chk_reset("midrst");
    rst = 1'b0;

    // Backpressure: every accepted pair must appear once, in order, one per frame.
    k = 1; l_s = 24'(k); r_s = 24'(k + 32'h100);
    en = 1'b1; s_valid = 1'b1;
    step(1);
    f = -1; rdy_cnt = 0;
    for (int c = 0; c < 5 * 64; c++) begin
      if (fs0) begin
        if (f >= 0) chk($sformatf("bp.rdy_per_frame%0d", f), 32'(rdy_cnt), 32'd1);
        f++;
        rdy_cnt = 0;
        if (f >= 1) begin
          chk($sformatf("bp.lw%0d", f), lw0, 32'(f) << 8);
          chk($sformatf("bp.rw%0d", f), rw0, 32'(f + 32'h100) << 8);
        end
      end
      if (rdy0) rdy_cnt++;
      go = rdy0;
      step(1);
      if (go) begin
        k++;
        l_s = 24'(k);
        r_s = 24'(k + 32'h100);
      end
    end
    chk("bp.frames", 32'(f), 32'd4);
    chk("bp.noun", 32'(ur0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sched.md
# i2s_tx_sched

Transmit-side frame scheduler for the I2S output path. It generates the bit counter and `lrck` framing, pulls stereo sample pairs from an upstream source through a valid/ready handshake into a one-entry holding buffer, and presents left-justified, zero-padded words to the `i2s_tx` serializer once per frame. It handles start/stop sequencing, mute, and underrun detection and counting.

## Interface
- `WORD_SIZE`, 32: bits per channel slot; a frame is 2*WORD_SIZE bck cycles.
- `SAMPLE_SIZE`, 24: signed sample width, ≤ WORD_SIZE.
- `UNDERRUN_HOLD`, 0: on underrun, 0 sends zero words and 1 repeats the last loaded words.
- `bck` in, 1: bit clock. All state changes on the falling edge of bck.
- `rst` in, 1: synchronous, active-high reset, sampled on the falling edge of bck.
- `en` in, 1: run request.
- `mute` in, 1: force zero words at the load edge.
- `s_valid` in, 1: upstream sample pair valid.
- `s_ready` out, 1: holding buffer can accept.
- `s_l_sample` in, SAMPLE_SIZE: left sample.
- `s_r_sample` in, SAMPLE_SIZE: right sample.
- `lrck` out, 1: 0 = left slot, 1 = right slot. Drives `i2s_tx`.
- `l_word` out, WORD_SIZE: left word to `i2s_tx`.
- `r_word` out, WORD_SIZE: right word to `i2s_tx`.
- `frame_start` out, 1: one-cycle pulse on the first bit of each frame.
- `underrun` out, 1: sticky underrun flag.
- `underrun_clr` in, 1: clears `underrun`.
- `underrun_cnt` out, 8: saturating underrun count. Cleared only by `rst`.

## Operation
- **States.**
  - IDLE: `lrck`=0, `bit_cnt`=0, words=0, `s_ready`=0.
  - RUN: framing active.
  - STOP: finish the current frame, then return to IDLE.
- **Transitions.**
  - IDLE→RUN when `en`=1. The first RUN cycle has `bit_cnt`=0, `lrck`=0, and `frame_start`=1.
  - RUN→STOP when `en`=0.
  - STOP→RUN when `en` returns to 1 before the load edge. Framing is not disturbed.
  - STOP→IDLE at the load edge.
- **Framing.**
  - `bit_cnt` counts 0..WORD_SIZE-1 and wraps to 0.
  - `lrck` toggles on the edge where `bit_cnt`=WORD_SIZE-1.
- **Load edge.** The falling edge where `lrck`=1 and `bit_cnt`=WORD_SIZE-1, i.e. the same edge on which `lrck` goes 1→0.
- **Holding buffer.** A one-entry register pair plus a `pend_full` bit.
  - `s_ready` = `!pend_full` while in RUN or STOP; it is 0 in IDLE.
  - Handshake occurs on a falling edge with `s_valid`=1 and `s_ready`=1; the pair is captured and `pend_full` is set.
- **At the load edge, in RUN.**
  - If `pend_full`: `l_word`={pend_l, (WORD_SIZE-SAMPLE_SIZE)'b0}, `r_word` likewise, and `pend_full` clears. If `mute`=1, the words are forced to 0, the pair is still consumed, and no underrun is flagged.
  - Else (underrun): words become 0, or are left unchanged if UNDERRUN_HOLD=1. `underrun` sets and `underrun_cnt` increments, saturating at 255. `mute` does not suppress underrun detection.
- **At the load edge, in STOP.** Words become 0, `pend_full` clears (the pending pair is discarded), no underrun is flagged, and the next state is IDLE.
- **Boundary cases.**
  - A handshake on the load edge can only occur when `pend_full` was 0. That edge is an underrun, and the new pair is held for the following frame.
  - `underrun_clr` and an underrun on the same edge: set wins.
  - `rst` overrides everything, including mid-frame. All outputs return to reset values on the next edge.
- **Reset values.** IDLE, `lrck`=0, `l_word`=`r_word`=0, `s_ready`=0, `frame_start`=0, `underrun`=0, `underrun_cnt`=0, `pend_full`=0.

## Timing
- All outputs are registered. `s_ready` is derived from registered state only, with no combinational path from `s_valid`.
- `l_word`/`r_word` change only at the load edge and are stable for the entire following frame.
- `frame_start` is high during the bck cycle with `bit_cnt`=0 and `lrck`=0.
- **Latency.** A pair accepted at edge t is loaded at the first load edge after t. It appears on `l_word` for the whole next frame, i.e. at most 2*WORD_SIZE bck cycles after acceptance.
- **Throughput.** One pair per frame. After a load, `s_ready` reasserts on the next bck cycle.

## Test plan
All scenarios use WORD_SIZE=32 and SAMPLE_SIZE=24.

- **Reset, then enable, fed continuously.** Pulse `rst`, raise `en`, keep `s_valid`=1 with L=0x7FFFFF, R=0x800000.
  - `frame_start` occurs every 64 bck; `lrck` has 32 low / 32 high.
  - From the 2nd frame, `l_word`=0x7FFFFF00 and `r_word`=0x80000000.
  - `underrun` stays 0.
- **Underrun.** Stop `s_valid` after 3 pairs.
  - With UNDERRUN_HOLD=0: words become 0 at the 4th load edge, `underrun`=1, `underrun_cnt` increments once per starved frame.
  - With UNDERRUN_HOLD=1: words keep the 3rd pair.
- **Backpressure.** Hold `s_valid`=1 with incrementing samples. `s_ready` is high one cycle per frame; every sample appears exactly once, in order, with no drops.
- **Mute.** Assert `mute` across one load edge while a pair is pending. That frame's words are 0, the pair is consumed, `underrun` stays 0, and the next pair loads normally.
- **Stop mid-frame.** Drop `en` at `bit_cnt`=10 of the left slot.
  - Framing continues to the load edge.
  - At the load edge: words=0, `lrck`=0, IDLE, `s_ready`=0, and the pending pair is discarded.
- **Edge collisions.**
  - `underrun_clr` asserted on an underrun edge: `underrun` stays 1.
  - `rst` asserted mid-right-slot: all outputs are at reset values the next cycle.
  - Starve `underrun_cnt` past 255 frames: it holds at 255.
